// File: rtl/aes_mode_pkg.sv
// Shared types and constants for the AES block-mode sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Macro AES_CTR_MODE_EN decides whether CTR is a legal mode.
package aes_mode_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB = 2'd0,
        MODE_CBC = 2'd1,
        MODE_CTR = 2'd2,
        MODE_ILL = 2'd3
    } aes_mode_e;

    typedef enum logic [2:0] {
        ST_NOKEY = 3'd0,
        ST_KEYX  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4
    } aes_state_e;

    localparam logic [2:0] FUNC_DEC    = 3'h0;
    localparam logic [2:0] FUNC_ENC    = 3'h1;
    localparam logic [2:0] FUNC_KEYEXP = 3'h2;

    // One queued input block with its end-of-message marker.
    typedef struct packed {
        logic             last;
        logic [BLK_W-1:0] data;
    } blk_t;

    // A mode is legal only if this build can actually execute it.
    function automatic logic mode_legal(input logic [1:0] m);
`ifdef AES_CTR_MODE_EN
        return (m != MODE_ILL);
`else
        return (m == MODE_ECB) || (m == MODE_CBC);
`endif
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Input-block FIFO: DEPTH entries of WIDTH bits, first-word fall-through read port.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: full blocks a push unless a pop happens in the same cycle; flush empties it.
module aes_blk_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush behaves like reset for the occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are don't-care while the entry is not occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/aes_mode_seq.sv
// ECB/CBC/CTR block-mode sequencer in front of an external single-block AES core.
// Latency: core_start the cycle after a block reaches the FIFO head in IDLE; out_valid the cycle after core_done.
// Backpressure: one result held until out_ready; input stalls when the FIFO is full. AES_CTR_MODE_EN adds CTR.
module aes_mode_seq
    import aes_mode_pkg::*;
#(
    parameter int KEY_BITS   = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                eph1,
    input  logic                reset,
    input  logic                cfg_load,
    input  logic [1:0]          cfg_mode,
    input  logic                cfg_decrypt,
    input  logic [BLK_W-1:0]    cfg_iv,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK_W-1:0]    in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK_W-1:0]    out_data,
    output logic                out_last,
    output logic                core_start,
    output logic [2:0]          core_func,
    output logic [BLK_W-1:0]    core_text,
    output logic [KEY_BITS-1:0] core_key,
    input  logic                core_done,
    input  logic [BLK_W-1:0]    core_result,
    output logic                busy,
    output logic                err
);

    aes_state_e          state_q, state_d;
    aes_mode_e           mode_q;
    logic                decrypt_q;
    logic [BLK_W-1:0]    iv_q;
    logic [BLK_W-1:0]    chain_q;
    logic [KEY_BITS-1:0] key_q;
    logic                err_q;
    logic                key_started_q;
    blk_t                cur_q;
`ifdef AES_CTR_MODE_EN
    logic [BLK_W-1:0]    ctr_q;
`endif

    logic                out_valid_q;
    logic [BLK_W-1:0]    out_data_q;
    logic                out_last_q;
    logic                core_start_q;
    logic [2:0]          core_func_q;
    logic [BLK_W-1:0]    core_text_q;

    blk_t                fifo_wdata;
    blk_t                head;
    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

    logic                issue_key, issue_blk, take_result, out_fire;
    logic [2:0]          blk_func;
    logic [BLK_W-1:0]    blk_text;
    logic [BLK_W-1:0]    res_data;

    assign in_ready   = ~fifo_full & (state_q != ST_NOKEY);
    assign fifo_push  = in_valid & in_ready;
    assign fifo_wdata = '{last: in_last, data: in_data};

    aes_blk_fifo #(
        .WIDTH ($bits(blk_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (eph1),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge eph1) begin
        if (reset) state_q <= ST_NOKEY;
        else       state_q <= state_d;
    end

    // Next state and one-cycle control strobes; a new configuration overrides everything.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        issue_key   = 1'b0;
        issue_blk   = 1'b0;
        take_result = 1'b0;
        out_fire    = 1'b0;
        if (cfg_load) begin
            state_d    = ST_KEYX;
            fifo_flush = (state_q == ST_RUN) || (state_q == ST_HOLD);
        end else begin
            case (state_q)
                ST_NOKEY: state_d = ST_NOKEY;
                // A done seen before or alongside our own start belongs to an abandoned op.
                ST_KEYX: begin
                    if (!key_started_q)                  issue_key = 1'b1;
                    else if (core_done && !core_start_q) state_d   = ST_IDLE;
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        issue_blk = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        take_result = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_fire = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_NOKEY;
            endcase
        end
    end

    // Core request for the block at the FIFO head, per mode.
    always_comb begin
        blk_text = head.data;
        blk_func = decrypt_q ? FUNC_DEC : FUNC_ENC;
        case (mode_q)
            MODE_CBC: if (!decrypt_q) blk_text = head.data ^ chain_q;
`ifdef AES_CTR_MODE_EN
            MODE_CTR: begin
                blk_text = ctr_q;
                blk_func = FUNC_ENC;
            end
`endif
            default: blk_text = head.data;
        endcase
    end

    // Output block from the core result, per mode.
    always_comb begin
        res_data = core_result;
        case (mode_q)
            MODE_CBC: if (decrypt_q) res_data = core_result ^ chain_q;
`ifdef AES_CTR_MODE_EN
            MODE_CTR: res_data = core_result ^ cur_q.data;
`endif
            default: res_data = core_result;
        endcase
    end

    // Configuration, chaining state, core request and output registers.
    always_ff @(posedge eph1) begin
        if (reset) begin
            mode_q        <= MODE_ECB;
            decrypt_q     <= 1'b0;
            iv_q          <= '0;
            chain_q       <= '0;
            key_q         <= '0;
            err_q         <= 1'b0;
            key_started_q <= 1'b0;
            cur_q         <= '0;
`ifdef AES_CTR_MODE_EN
            ctr_q         <= '0;
`endif
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            core_start_q  <= 1'b0;
            core_func_q   <= 3'h0;
            core_text_q   <= '0;
        end else begin
            core_start_q <= 1'b0;
            if (cfg_load) begin
                mode_q        <= mode_legal(cfg_mode) ? aes_mode_e'(cfg_mode) : MODE_ECB;
                decrypt_q     <= cfg_decrypt;
                iv_q          <= cfg_iv;
                chain_q       <= cfg_iv;
`ifdef AES_CTR_MODE_EN
                ctr_q         <= cfg_iv;
`endif
                key_q         <= key;
                key_started_q <= 1'b0;
                out_valid_q   <= 1'b0;
                if (!mode_legal(cfg_mode)) err_q <= 1'b1;
            end
            if (issue_key) begin
                core_start_q  <= 1'b1;
                core_func_q   <= FUNC_KEYEXP;
                key_started_q <= 1'b1;
            end
            if (issue_blk) begin
                core_start_q <= 1'b1;
                core_func_q  <= blk_func;
                core_text_q  <= blk_text;
                cur_q        <= head;
            end
            if (take_result) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                out_last_q  <= cur_q.last;
                if (mode_q == MODE_CBC) chain_q <= decrypt_q ? cur_q.data : core_result;
`ifdef AES_CTR_MODE_EN
                if (mode_q == MODE_CTR) ctr_q <= ctr_q + 128'd1;
`endif
            end
            if (out_fire) begin
                out_valid_q <= 1'b0;
                if (out_last_q) begin
                    chain_q <= iv_q;
`ifdef AES_CTR_MODE_EN
                    ctr_q   <= iv_q;
`endif
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign core_start = core_start_q;
    assign core_func  = core_func_q;
    assign core_text  = core_text_q;
    assign core_key   = key_q;
    assign err        = err_q;
    // NOKEY counts as quiescent so that busy reads 0 straight out of reset.
    assign busy = ((state_q != ST_IDLE) && (state_q != ST_NOKEY)) || !fifo_empty;

endmodule
